// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_ctrl_pkg
// Brief  : Shared types for the single-port SRAM controller.
// Rev    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    localparam int c_FIFO_DEPTH = 2;

    function automatic prio_e flip_prio(input prio_e p);
        return (p == PRIO_WR) ? PRIO_RD : PRIO_WR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module : sram_rsp_fifo
// Brief  : 2-entry first-word-fall-through response FIFO, registered head.
// Rev    : 1.0 - initial release
// ============================================================================
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [c_FIFO_DEPTH];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem   <= '{default: '0};
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sram_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sram_sp_ctrl
// Brief  : Single-port SRAM controller: init sweep, round-robin R/W
//          arbitration and a backpressured read-response path.
// Rev    : 1.0 - initial release
// ============================================================================
module sram_sp_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                DATA_W   = 2,
    parameter int                DEPTH    = 512,
    parameter int                ADDR_W   = 9,
    parameter int                INIT_EN  = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam state_e            c_RST_STATE = (INIT_EN != 0) ? INIT : RUN;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    prio_e             r_rr_prio;
    prio_e             w_prio_nxt;
    logic [ADDR_W-1:0] r_init_ptr;
    logic              r_s1_valid;
    logic              w_gnt_wr;
    logic              w_gnt_rd;
    logic              w_can_rd;
    logic              w_pop;
    logic [1:0]        w_fifo_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_RST_STATE;
            r_rr_prio  <= PRIO_WR;
            r_init_ptr <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_prio  <= w_prio_nxt;
            r_s1_valid <= w_gnt_rd;
            if (r_state == INIT) begin
                r_init_ptr <= r_init_ptr + ADDR_W'(1);
            end
        end
    end

    // A read may issue only if its data is guaranteed a FIFO slot on arrival.
    assign w_pop    = rsp_valid && rsp_ready;
    assign w_can_rd = ((2'(r_s1_valid) + w_fifo_count) < 2'd2) || w_pop;

    // Gating on reset_n keeps the macro idle while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_rr_prio;
        w_gnt_wr    = 1'b0;
        w_gnt_rd    = 1'b0;
        sram_ceb    = 1'b1;
        sram_web    = 1'b1;
        sram_a      = '0;
        sram_d      = '0;
        if (reset_n) begin
            case (r_state)
                INIT: begin
                    sram_ceb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = r_init_ptr;
                    sram_d   = INIT_VAL;
                    if (r_init_ptr == c_LAST_ADDR) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (wr_valid && rd_valid && w_can_rd) begin
                        w_gnt_wr   = (r_rr_prio == PRIO_WR);
                        w_gnt_rd   = (r_rr_prio == PRIO_RD);
                        w_prio_nxt = flip_prio(r_rr_prio);
                    end else if (wr_valid) begin
                        w_gnt_wr = 1'b1;
                    end else if (rd_valid && w_can_rd) begin
                        w_gnt_rd = 1'b1;
                    end
                    if (w_gnt_wr) begin
                        sram_ceb = 1'b0;
                        sram_web = 1'b0;
                        sram_a   = wr_addr;
                        sram_d   = wr_data;
                    end else if (w_gnt_rd) begin
                        sram_ceb = 1'b0;
                        sram_a   = rd_addr;
                    end
                end
                default: w_state_nxt = c_RST_STATE;
            endcase
        end
    end

    assign init_busy = (r_state == INIT);
    assign wr_ready  = w_gnt_wr;
    assign rd_ready  = w_gnt_rd;

    sram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (r_s1_valid),
        .i_data  (sram_q),
        .i_pop   (w_pop),
        .o_valid (rsp_valid),
        .o_data  (rsp_data),
        .o_count (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_sp_ctrl
// Brief  : Self-checking bench for sram_sp_ctrl against a cycle-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sram_sp_ctrl;

    localparam int         DW    = 2;
    localparam int         DEPTH = 512;
    localparam int         AW    = 9;
    localparam logic [1:0] IV    = 2'b11;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          init_busy, wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, sram_a;
    logic [DW-1:0] wr_data, rsp_data, sram_d, sram_q;
    logic          rsp_valid, rsp_ready, sram_ceb, sram_web;

    sram_sp_ctrl #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_EN(1), .INIT_VAL(IV)
    ) dut (
        .clock(clock), .reset_n(reset_n), .init_busy(init_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q)
    );

    always #5 clock = ~clock;

    // Macro model: Q is garbage on any non-read cycle.
    logic [DW-1:0] mac_mem [DEPTH];
    always @(posedge clock) begin
        if (!sram_ceb && !sram_web) mac_mem[sram_a] <= sram_d;
        if (!sram_ceb && sram_web) sram_q <= mac_mem[sram_a];
        else                       sram_q <= DW'($urandom);
    end

    // Reference model state
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    bit            m_init;
    int            m_ptr;
    bit            m_prio_rd;
    logic [DW-1:0] ref_mem [DEPTH];
    rsp_t          pend [$];
    int            cyc;

    logic          obs_wr_ready, obs_rd_ready, obs_ceb, obs_web, obs_busy, obs_rsp_valid;
    logic [AW-1:0] obs_a;
    logic [DW-1:0] obs_d, obs_rsp_data;
    logic          exp_wr_ready, exp_rd_ready, exp_ceb, exp_web, exp_busy, exp_rsp_valid;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d, exp_rsp_data;
    logic [15:0]   obs_ctl, exp_ctl;
    logic [17:0]   rst_vec;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic model_reset();
        m_init    = 1'b1;
        m_ptr     = 0;
        m_prio_rd = 1'b0;
        pend.delete();
    endtask

    // One clock cycle: drive at negedge, sample + predict, then advance model.
    task automatic step(input logic wv, input logic rv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] ra, input logic rr);
        bit can_rd, pop;
        wr_valid = wv; rd_valid = rv; wr_addr = wa; wr_data = wd; rd_addr = ra; rsp_ready = rr;
        #1;
        obs_wr_ready = wr_ready; obs_rd_ready = rd_ready; obs_ceb = sram_ceb; obs_web = sram_web;
        obs_a = sram_a; obs_d = sram_d; obs_busy = init_busy;
        obs_rsp_valid = rsp_valid; obs_rsp_data = rsp_data;

        exp_wr_ready = 1'b0; exp_rd_ready = 1'b0; exp_ceb = 1'b1; exp_web = 1'b1;
        exp_a = '0; exp_d = '0; exp_busy = m_init;
        exp_rsp_valid = (pend.size() > 0) && (pend[0].due <= cyc);
        exp_rsp_data  = (pend.size() > 0) ? pend[0].data : '0;
        pop = exp_rsp_valid && rr;
        if (m_init) begin
            exp_ceb = 1'b0; exp_web = 1'b0; exp_a = AW'(m_ptr); exp_d = IV;
        end else begin
            can_rd = (pend.size() < 2) || pop;
            if (wv && rv && can_rd) begin
                if (m_prio_rd) exp_rd_ready = 1'b1;
                else           exp_wr_ready = 1'b1;
                m_prio_rd = !m_prio_rd;
            end else if (wv) begin
                exp_wr_ready = 1'b1;
            end else if (rv && can_rd) begin
                exp_rd_ready = 1'b1;
            end
            if (exp_wr_ready) begin
                exp_ceb = 1'b0; exp_web = 1'b0; exp_a = wa; exp_d = wd;
            end else if (exp_rd_ready) begin
                exp_ceb = 1'b0; exp_a = ra;
            end
        end
        obs_ctl = {obs_wr_ready, obs_rd_ready, obs_ceb, obs_web, obs_a, obs_d, obs_busy};
        exp_ctl = {exp_wr_ready, exp_rd_ready, exp_ceb, exp_web, exp_a, exp_d, exp_busy};

        @(posedge clock);
        if (pop) void'(pend.pop_front());
        if (m_init) begin
            ref_mem[m_ptr] = IV;
            if (m_ptr == DEPTH - 1) m_init = 1'b0;
            else                    m_ptr++;
        end
        if (exp_wr_ready) ref_mem[wa] = wd;
        if (exp_rd_ready) pend.push_back('{data: ref_mem[ra], due: cyc + 2});
        cyc++;
        @(negedge clock);
    endtask

    task automatic reset_low();
        wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
        wr_addr = 9'h1A5; wr_data = 2'b10; rd_addr = 9'h0F3;
        reset_n = 1'b0;
        #1;
        rst_vec = {sram_ceb, sram_web, sram_a, sram_d, wr_ready, rd_ready, rsp_valid, rsp_data};
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    localparam logic [17:0] c_RST_EXP = {1'b1, 1'b1, 9'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0};

    task automatic test_reset();
        @(negedge clock);
        reset_low();
        n_cmp++;
        if (rst_vec !== c_RST_EXP) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", rst_vec, c_RST_EXP);
        end
        n_cmp++;
        if (init_busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b want 1", init_busy);
        end
        reset_release();
    endtask

    task automatic test_init_sweep(input string tag);
        int n_init_wr;
        n_init_wr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 9'd7, 2'b01, 9'd9, 1'b1);
            if (!obs_ceb && !obs_web && obs_a == AW'(i) && obs_d == IV && obs_busy) n_init_wr++;
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin
                n_fail++; $display("FAIL %s_ctl i=%0d: got %h want %h", tag, i, obs_ctl, exp_ctl);
            end
        end
        n_cmp++;
        if (n_init_wr !== DEPTH) begin
            n_fail++; $display("FAIL %s_count: got %0d want %0d", tag, n_init_wr, DEPTH);
        end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_cmp++;
        if (obs_busy !== 1'b0 || obs_ctl !== exp_ctl) begin
            n_fail++; $display("FAIL %s_done: got busy=%b ctl=%h want busy=0 ctl=%h", tag, obs_busy, obs_ctl, exp_ctl);
        end
    endtask

    task automatic test_init_readback();
        logic [AW-1:0] addrs [3];
        addrs[0] = 9'd0; addrs[1] = 9'd255; addrs[2] = 9'd511;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, '0, '0, addrs[k], 1'b1);
            n_cmp++;
            if (obs_rd_ready !== 1'b1 || obs_ctl !== exp_ctl) begin
                n_fail++; $display("FAIL readback_req a=%0d: got %h want %h", addrs[k], obs_ctl, exp_ctl);
            end
            step(1'b0, 1'b0, '0, '0, '0, 1'b1);
            step(1'b0, 1'b0, '0, '0, '0, 1'b1);
            n_cmp++;
            if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== IV) begin
                n_fail++; $display("FAIL readback_data a=%0d: got v=%b d=%b want v=1 d=%b",
                                   addrs[k], obs_rsp_valid, obs_rsp_data, IV);
            end
        end
    endtask

    task automatic test_write_then_read();
        step(1'b1, 1'b0, 9'd5, 2'b01, '0, 1'b1);
        n_cmp++;
        if (obs_ctl !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd5, 2'b01, 1'b0}) begin
            n_fail++; $display("FAIL wr5_ctl: got %h want write a=5 d=01", obs_ctl);
        end
        step(1'b0, 1'b1, '0, '0, 9'd5, 1'b1);
        n_cmp++;
        if (obs_ctl !== {1'b0, 1'b1, 1'b0, 1'b1, 9'd5, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL rd5_ctl: got %h want read a=5", obs_ctl);
        end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_cmp++;
        if (obs_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd5_early: got rsp_valid=%b want 0", obs_rsp_valid);
        end
        step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        n_cmp++;
        if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== 2'b01) begin
            n_fail++; $display("FAIL rd5_data: got v=%b d=%b want v=1 d=01", obs_rsp_valid, obs_rsp_data);
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, AW'($urandom_range(16, 31)), DW'($urandom), AW'($urandom_range(16, 31)), 1'b1);
            n_cmp++;
            if (obs_wr_ready !== (i % 2 == 0) || obs_rd_ready !== (i % 2 == 1) || obs_ctl !== exp_ctl) begin
                n_fail++; $display("FAIL alt_grant i=%0d: got %h want %h", i, obs_ctl, exp_ctl);
            end
            n_cmp++;
            if (obs_rsp_valid !== exp_rsp_valid || (exp_rsp_valid && obs_rsp_data !== exp_rsp_data)) begin
                n_fail++; $display("FAIL alt_rsp i=%0d: got v=%b d=%b want v=%b d=%b",
                                   i, obs_rsp_valid, obs_rsp_data, exp_rsp_valid, exp_rsp_data);
            end
        end
        repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int           idx, n_acc;
        logic [DW-1:0] got [$];
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(i + 1), DW'(i), '0, 1'b1);
        idx = 0; n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, idx < 4, '0, '0, AW'(idx + 1), 1'b0);
            if (obs_rd_ready) n_acc++;
            if (exp_rd_ready) idx++;
            n_cmp++;
            if (obs_ctl !== exp_ctl || obs_rsp_valid !== exp_rsp_valid
                || (obs_rsp_valid && obs_rsp_data !== 2'b00)) begin
                n_fail++; $display("FAIL b2b_hold c=%0d: got ctl=%h v=%b d=%b want ctl=%h v=%b d=00",
                                   c, obs_ctl, obs_rsp_valid, obs_rsp_data, exp_ctl, exp_rsp_valid);
            end
        end
        n_cmp++;
        if (n_acc !== 2) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d want 2", n_acc);
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, idx < 4, '0, '0, AW'(idx + 1), 1'b1);
            if (exp_rd_ready) idx++;
            if (obs_rsp_valid) got.push_back(obs_rsp_data);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin
                n_fail++; $display("FAIL b2b_drain_ctl c=%0d: got %h want %h", c, obs_ctl, exp_ctl);
            end
        end
        n_cmp++;
        if (got.size() !== 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 4", got.size());
        end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            n_cmp++;
            if (got[k] !== DW'(k)) begin
                n_fail++; $display("FAIL b2b_order k=%0d: got %0d want %0d", k, got[k], k);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
                 AW'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin
                n_fail++; $display("FAIL rand_ctl i=%0d: got %h want %h", i, obs_ctl, exp_ctl);
            end
            n_cmp++;
            if (obs_rsp_valid !== exp_rsp_valid || (exp_rsp_valid && obs_rsp_data !== exp_rsp_data)) begin
                n_fail++; $display("FAIL rand_rsp i=%0d: got v=%b d=%b want v=%b d=%b",
                                   i, obs_rsp_valid, obs_rsp_data, exp_rsp_valid, exp_rsp_data);
            end
        end
        repeat (4) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic test_reset_mid_sweep();
        reset_low();
        reset_release();
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        reset_low();
        n_cmp++;
        if (rst_vec !== c_RST_EXP) begin
            n_fail++; $display("FAIL midsweep_reset: got %h want %h", rst_vec, c_RST_EXP);
        end
        reset_release();
        test_init_sweep("resweep");
    endtask

    task automatic test_reset_inflight();
        int stale;
        step(1'b0, 1'b1, '0, '0, 9'd3, 1'b0);
        step(1'b0, 1'b1, '0, '0, 9'd4, 1'b0);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL inflight_pre: got rsp_valid=%b want 1", rsp_valid);
        end
        reset_low();
        n_cmp++;
        if (rst_vec !== c_RST_EXP) begin
            n_fail++; $display("FAIL inflight_reset: got %h want %h", rst_vec, c_RST_EXP);
        end
        reset_release();
        stale = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1);
            if (obs_rsp_valid) stale++;
        end
        n_cmp++;
        if (stale !== 0) begin
            n_fail++; $display("FAIL inflight_stale: got %0d responses want 0", stale);
        end
    endtask

    initial begin
        cyc = 0;
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        model_reset();
        test_reset();
        test_init_sweep("sweep");
        test_init_readback();
        test_write_then_read();
        test_alternate();
        test_back_to_back();
        test_random();
        test_reset_mid_sweep();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
